up_wishbone_classic_master: RTL and testbench
=============================================

UP_WISHBONE_CLASSIC_MASTER -- requirements
Module: up_wishbone_classic_master

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, Wishbone byte-address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 4, data bus width in bytes.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum Wishbone cycles to wait for ack/err (1..65535).
REQ-004 SHALL use one clock; reset is asynchronous and active-high: clk input 1 (all logic on rising edge); rst input 1 (async, active-high).
REQ-005 up_rreq input 1; read request, held until up_rack.
REQ-006 up_rack output 1; one-cycle read-complete pulse.
REQ-007 up_raddr input ADDRESS_WIDTH-log2(BUS_WIDTH); word read address.
REQ-008 up_rdata output BUS_WIDTH*8; read data, valid while up_rack high.
REQ-009 up_wreq input 1; write request, held until up_wack.
REQ-010 up_wack output 1; one-cycle write-complete pulse.
REQ-011 up_waddr input ADDRESS_WIDTH-log2(BUS_WIDTH); word write address.
REQ-012 up_wdata input BUS_WIDTH*8; write data.
REQ-013 up_err output 1; pulses with up_rack/up_wack when the transfer ended by m_wb_err or timeout.
REQ-014 m_wb_cyc, m_wb_stb, m_wb_we outputs 1; Wishbone classic master controls.
REQ-015 m_wb_addr output ADDRESS_WIDTH; byte address; m_wb_data_o output BUS_WIDTH*8; m_wb_sel output BUS_WIDTH.
REQ-016 m_wb_cti output 3, constant 3'b000; m_wb_bte output 2, constant 2'b00.
REQ-017 m_wb_data_i input BUS_WIDTH*8; m_wb_ack input 1; m_wb_err input 1.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, READ, RESP; reset state IDLE.
REQ-019 IDLE: up_wreq high -> latch up_waddr/up_wdata, go WRITE; else up_rreq high -> latch up_raddr, go READ; both high -> write wins, read serviced after write completes.
REQ-020 m_wb_addr SHALL equal latched word address concatenated with log2(BUS_WIDTH) zero bits (word 14'h3 -> 16'h000C).
REQ-021 In WRITE/READ: m_wb_cyc=m_wb_stb=1, m_wb_sel all ones, m_wb_we=1 in WRITE, 0 in READ; addr/data stable for whole cycle; first asserted the cycle after the request is sampled in IDLE.
REQ-022 Termination sampled on rising edge with stb high: m_wb_ack, m_wb_err, or wait counter reaching TIMEOUT; next cycle cyc/stb/we SHALL be 0 and state RESP.
REQ-023 RESP (exactly one cycle): pulse up_wack (write) or up_rack (read); return to IDLE; no new request accepted during RESP.
REQ-024 Read on ack: up_rdata SHALL hold m_wb_data_i captured at the ack edge; on err/timeout: up_rdata = 32'hDEADDEAD (replicated for wider buses).
REQ-025 up_err SHALL be 1 in RESP iff termination was m_wb_err or timeout; ack and err together count as err.
REQ-026 Wait counter SHALL clear on entering WRITE/READ, increment each cycle without ack/err, saturate-free (terminates at TIMEOUT).
REQ-027 up_rdata SHALL hold its last value outside RESP.
REQ-028 Request latency: req sampled at edge N -> stb at N+1; ack at edge M -> up_*ack high cycle M+1..M+2 edge; minimum 3 cycles req-to-ack with zero-wait slave.
REQ-029 Requester SHALL drop req after its ack; req still high when IDLE re-entered starts a new transfer.

Reset
REQ-030 rst high SHALL immediately force IDLE, all Wishbone outputs (cyc, stb, we, addr, data_o) 0, m_wb_sel 0, up_rack/up_wack/up_err 0, up_rdata 0, counter 0.
REQ-031 rst asserted mid-transfer SHALL abort the Wishbone cycle with no up ack pulse; first transfer after release starts from IDLE.

Verification
REQ-032 Write: up_waddr=14'h3, up_wdata=32'hAAAA0002, slave acks 1 cycle after stb -> m_wb_addr=16'h000C, we=1, data_o=32'hAAAA0002, one up_wack pulse, up_err=0.
REQ-033 Read: up_raddr=14'h2, slave returns 32'hB0BDBEEF with ack -> one up_rack pulse, up_rdata=32'hB0BDBEEF, we=0 throughout.
REQ-034 Simultaneous up_wreq/up_rreq in IDLE -> write cycle first, wack, then read cycle, rack; never overlap.
REQ-035 Slave never acks, TIMEOUT=8 -> stb high exactly 8 cycles, then cyc=0, up_rack with up_err=1, up_rdata=32'hDEADDEAD.
REQ-036 Slave asserts m_wb_err on write -> up_wack with up_err=1; next transfer completes normally with up_err=0.
REQ-037 rst pulsed while stb high -> cyc/stb 0 asynchronously, no up_wack; subsequent write to 14'h0 completes normally.

Source files
------------

// File: rtl/up_wishbone_classic_master.sv
// Bridges a word-addressed up_* request port onto single classic Wishbone transfers,
// with a wait-cycle timeout that ends a transfer with an error response.
//
// state | meaning
// IDLE  | wait for up_wreq / up_rreq (write has priority)
// WRITE | Wishbone write cycle in progress
// READ  | Wishbone read cycle in progress
// RESP  | one-cycle up_wack / up_rack pulse back to the requester

module up_wishbone_classic_master #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int BUS_WIDTH     = 4,
   parameter int TIMEOUT       = 255
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      up_rreq,
   output logic                                      up_rack,
   input  logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH)-1:0] up_raddr,
   output logic [BUS_WIDTH*8-1:0]                    up_rdata,
   input  logic                                      up_wreq,
   output logic                                      up_wack,
   input  logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH)-1:0] up_waddr,
   input  logic [BUS_WIDTH*8-1:0]                    up_wdata,
   output logic                                      up_err,
   output logic                                      m_wb_cyc,
   output logic                                      m_wb_stb,
   output logic                                      m_wb_we,
   output logic [ADDRESS_WIDTH-1:0]                  m_wb_addr,
   output logic [BUS_WIDTH*8-1:0]                    m_wb_data_o,
   output logic [BUS_WIDTH-1:0]                      m_wb_sel,
   output logic [2:0]                                m_wb_cti,
   output logic [1:0]                                m_wb_bte,
   input  logic [BUS_WIDTH*8-1:0]                    m_wb_data_i,
   input  logic                                      m_wb_ack,
   input  logic                                      m_wb_err
);

   localparam int              LSB      = $clog2(BUS_WIDTH);
   localparam int              DW       = BUS_WIDTH * 8;
   localparam logic [DW-1:0]   ERR_DATA = DW'({((DW + 31) / 32){32'hDEADDEAD}});
   localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

   state_t                   state_q;
   logic [15:0]              cnt_q;
   logic                     cyc_q, stb_q, we_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DW-1:0]            wdata_q;
   logic [BUS_WIDTH-1:0]     sel_q;
   logic                     rack_q, wack_q, err_q;
   logic [DW-1:0]            rdata_q;
   logic                     term;
   logic                     bad_end;

   // cnt_q counts wait edges already spent; the TIMEOUT-th stb edge ends the cycle
   assign term    = m_wb_ack || m_wb_err || (cnt_q == TMO_LAST);
   assign bad_end = m_wb_err || !m_wb_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         rack_q  <= 1'b0;
         wack_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         rack_q <= 1'b0;
         wack_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (up_wreq) begin
                  addr_q  <= ADDRESS_WIDTH'(up_waddr) << LSB;
                  wdata_q <= up_wdata;
                  we_q    <= 1'b1;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  sel_q   <= '1;
                  cnt_q   <= '0;
                  state_q <= WRITE;
               end else if (up_rreq) begin
                  addr_q  <= ADDRESS_WIDTH'(up_raddr) << LSB;
                  we_q    <= 1'b0;
                  cyc_q   <= 1'b1;
                  stb_q   <= 1'b1;
                  sel_q   <= '1;
                  cnt_q   <= '0;
                  state_q <= READ;
               end
            end
            WRITE, READ: begin
               if (term) begin
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  sel_q   <= '0;
                  err_q   <= bad_end;
                  state_q <= RESP;
                  if (state_q == READ) begin
                     rack_q  <= 1'b1;
                     rdata_q <= bad_end ? ERR_DATA : m_wb_data_i;
                  end else begin
                     wack_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 16'd1;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign up_rack     = rack_q;
   assign up_wack     = wack_q;
   assign up_err      = err_q;
   assign up_rdata    = rdata_q;
   assign m_wb_cyc    = cyc_q;
   assign m_wb_stb    = stb_q;
   assign m_wb_we     = we_q;
   assign m_wb_addr   = addr_q;
   assign m_wb_data_o = wdata_q;
   assign m_wb_sel    = sel_q;
   assign m_wb_cti    = 3'b000;
   assign m_wb_bte    = 2'b00;

endmodule

// File: tb/tb_up_wishbone_classic_master.sv
// Bench for up_wishbone_classic_master: vector table of single transfers plus
// hand-written priority and reset-abort sequences, responses checked via a scoreboard.

module tb_up_wishbone_classic_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        up_rreq = 1'b0, up_wreq = 1'b0;
   logic        up_rack, up_wack, up_err;
   logic [13:0] up_raddr = '0, up_waddr = '0;
   logic [31:0] up_rdata, up_wdata = '0;
   logic        m_wb_cyc, m_wb_stb, m_wb_we;
   logic [15:0] m_wb_addr;
   logic [31:0] m_wb_data_o;
   logic [3:0]  m_wb_sel;
   logic [2:0]  m_wb_cti;
   logic [1:0]  m_wb_bte;
   logic [31:0] m_wb_data_i = '0;
   logic        m_wb_ack = 1'b0, m_wb_err = 1'b0;

   up_wishbone_classic_master #(.ADDRESS_WIDTH(16), .BUS_WIDTH(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .up_rreq(up_rreq), .up_rack(up_rack), .up_raddr(up_raddr), .up_rdata(up_rdata),
      .up_wreq(up_wreq), .up_wack(up_wack), .up_waddr(up_waddr), .up_wdata(up_wdata),
      .up_err(up_err),
      .m_wb_cyc(m_wb_cyc), .m_wb_stb(m_wb_stb), .m_wb_we(m_wb_we), .m_wb_addr(m_wb_addr),
      .m_wb_data_o(m_wb_data_o), .m_wb_sel(m_wb_sel), .m_wb_cti(m_wb_cti), .m_wb_bte(m_wb_bte),
      .m_wb_data_i(m_wb_data_i), .m_wb_ack(m_wb_ack), .m_wb_err(m_wb_err)
   );

   always #5 clk = ~clk;

   // slave modes: 0 ack, 1 err, 2 never respond, 3 ack+err together
   typedef struct {
      logic        wr;
      logic [13:0] addr;
      logic [31:0] wdata;
      int          mode;
      int          delay;
      logic [31:0] sdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
      logic [15:0] exp_maddr;
      int          exp_stb;
   } vec_t;

   typedef struct {
      logic        rd;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sbq[$];
   exp_t        e;
   vec_t        vecs[7];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] last_rd = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (up_rack || up_wack)) begin
         chk("rack_wack_exclusive", {63'd0, up_rack & up_wack}, 64'd0);
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=rack%0b/wack%0b required=none", up_rack, up_wack);
         end else begin
            e = sbq.pop_front();
            chk("ack_kind", {63'd0, up_rack}, {63'd0, e.rd});
            chk("up_err", {63'd0, up_err}, {63'd0, e.err});
            if (e.rd) begin
               chk("up_rdata", {32'd0, up_rdata}, {32'd0, e.rdata});
               last_rd = e.rdata;
            end else begin
               chk("rdata_hold", {32'd0, up_rdata}, {32'd0, last_rd});
            end
         end
      end
   end

   task automatic do_xfer(input vec_t v, input int idx);
      exp_t x;
      int   w = 0, stbs = 0, lat = -1, bad = 0;
      x.rd = !v.wr; x.err = v.exp_err; x.rdata = v.exp_rdata;
      sbq.push_back(x);
      @(negedge clk);
      m_wb_data_i = v.sdata;
      if (v.wr) begin up_waddr = v.addr; up_wdata = v.wdata; up_wreq = 1'b1; end
      else begin up_raddr = v.addr; up_rreq = 1'b1; end
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (m_wb_stb) begin
            stbs++;
            if (m_wb_we !== v.wr || m_wb_sel !== 4'hF || m_wb_cyc !== 1'b1 ||
                m_wb_addr !== v.exp_maddr || (v.wr && m_wb_data_o !== v.wdata)) bad++;
            if (v.mode != 2 && w == v.delay) begin
               m_wb_ack = (v.mode == 0 || v.mode == 3);
               m_wb_err = (v.mode == 1 || v.mode == 3);
            end else begin
               m_wb_ack = 1'b0;
               m_wb_err = 1'b0;
            end
            w++;
         end else begin
            m_wb_ack = 1'b0;
            m_wb_err = 1'b0;
         end
         if (up_rack || up_wack) begin
            up_wreq = 1'b0;
            up_rreq = 1'b0;
            lat = c;
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         failures++;
         $display("FAIL xfer%0d_timeout actual=no_ack required=ack", idx);
         up_wreq = 1'b0;
         up_rreq = 1'b0;
         void'(sbq.pop_front());
      end
      chk($sformatf("xfer%0d_wb_ctrl_bad", idx), 64'(bad), 64'd0);
      chk($sformatf("xfer%0d_stb_cycles", idx), 64'(stbs), 64'(v.exp_stb));
      chk($sformatf("xfer%0d_latency", idx), 64'(lat), 64'(v.exp_stb));
      @(negedge clk);
      chk($sformatf("xfer%0d_pulse_width", idx), {62'd0, up_rack, up_wack}, 64'd0);
      chk($sformatf("xfer%0d_cyc_low", idx), {62'd0, m_wb_cyc, m_wb_stb}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      //            wr    addr      wdata         mode dly sdata         err   rdata         maddr     stb
      vecs[0] = '{1'b1, 14'h0003, 32'hAAAA0002, 0, 1, 32'h0,        1'b0, 32'h0,        16'h000C, 2};
      vecs[1] = '{1'b0, 14'h0002, 32'h0,        0, 0, 32'hB0BDBEEF, 1'b0, 32'hB0BDBEEF, 16'h0008, 1};
      vecs[2] = '{1'b0, 14'h0005, 32'h0,        2, 0, 32'h11111111, 1'b1, 32'hDEADDEAD, 16'h0014, 8};
      vecs[3] = '{1'b1, 14'h0010, 32'h55AA55AA, 1, 0, 32'h0,        1'b1, 32'h0,        16'h0040, 1};
      vecs[4] = '{1'b1, 14'h0011, 32'h01234567, 0, 2, 32'h0,        1'b0, 32'h0,        16'h0044, 3};
      vecs[5] = '{1'b0, 14'h3FFF, 32'h0,        3, 0, 32'h99999999, 1'b1, 32'hDEADDEAD, 16'hFFFC, 1};
      vecs[6] = '{1'b0, 14'h0007, 32'h0,        0, 6, 32'h12345678, 1'b0, 32'h12345678, 16'h001C, 7};

      repeat (3) @(negedge clk);
      chk("rst_wb_ctrl", {61'd0, m_wb_cyc, m_wb_stb, m_wb_we}, 64'd0);
      chk("rst_addr_data", {m_wb_addr, m_wb_data_o}, 64'd0);
      chk("rst_sel", {60'd0, m_wb_sel}, 64'd0);
      chk("rst_up_flags", {61'd0, up_rack, up_wack, up_err}, 64'd0);
      chk("rst_rdata", {32'd0, up_rdata}, 64'd0);
      chk("cti_bte", {59'd0, m_wb_cti, m_wb_bte}, 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) do_xfer(vecs[i], i);

      // simultaneous requests: write must finish before the read begins
      begin
         exp_t xw, xr;
         int   got_w = 0, got_r = 0, bad = 0, rd_stbs = 0;
         xw.rd = 1'b0; xw.err = 1'b0; xw.rdata = 32'h0;
         xr.rd = 1'b1; xr.err = 1'b0; xr.rdata = 32'hC0FFEE01;
         sbq.push_back(xw);
         sbq.push_back(xr);
         @(negedge clk);
         up_waddr = 14'h0021; up_wdata = 32'hFEEDF00D; up_raddr = 14'h0022;
         m_wb_data_i = 32'hC0FFEE01;
         up_wreq = 1'b1; up_rreq = 1'b1;
         for (int c = 0; c < 100 && got_r == 0; c++) begin
            @(negedge clk);
            if (m_wb_stb) begin
               if (got_w == 0 && (m_wb_we !== 1'b1 || m_wb_addr !== 16'h0084)) bad++;
               if (got_w != 0) begin
                  rd_stbs++;
                  if (m_wb_we !== 1'b0 || m_wb_addr !== 16'h0088) bad++;
               end
            end
            m_wb_ack = m_wb_stb;
            if (up_wack) begin up_wreq = 1'b0; got_w = c + 1; end
            if (up_rack) begin up_rreq = 1'b0; got_r = c + 1; end
         end
         m_wb_ack = 1'b0;
         up_wreq = 1'b0; up_rreq = 1'b0;
         chk("prio_bad_cycles", 64'(bad), 64'd0);
         chk("prio_write_first", {63'd0, (got_w > 0) && (got_r > got_w)}, 64'd1);
         chk("prio_read_stbs", 64'(rd_stbs), 64'd1);
      end

      // reset mid-transfer: cyc/stb drop at once, no up_wack, later write works
      begin
         int seen = 0;
         @(negedge clk);
         up_waddr = 14'h0020; up_wdata = 32'hCAFE0001; up_wreq = 1'b1;
         for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (m_wb_stb) seen = 1;
         end
         chk("abort_stb_seen", 64'(seen), 64'd1);
         #1 rst = 1'b1;
         #1;
         chk("abort_async_cyc_stb", {62'd0, m_wb_cyc, m_wb_stb}, 64'd0);
         chk("abort_async_flags", {61'd0, up_wack, up_rack, up_err}, 64'd0);
         up_wreq = 1'b0;
         last_rd = 32'h0;
         repeat (2) @(negedge clk);
         chk("abort_rdata_cleared", {32'd0, up_rdata}, 64'd0);
         rst = 1'b0;
         repeat (2) @(negedge clk);
         chk("abort_idle_after", {62'd0, m_wb_cyc, up_wack}, 64'd0);
      end

      begin
         vec_t v0;
         v0 = '{1'b1, 14'h0000, 32'h0BADC0DE, 0, 0, 32'h0, 1'b0, 32'h0, 16'h0000, 1};
         do_xfer(v0, 7);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
